cordic_iter_ctrl: RTL and testbench

CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

---
 rtl/cordic_iter_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// Iteration controller for a CORDIC rotator driving an external registered shift-accumulate stage.
// Define CORDIC_QUADRANT_CORRECTION_EN to pre-rotate operands whose angle lies beyond +/-90 degrees.
module cordic_iter_ctrl #(
   parameter int ITERATIONS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] x_in,
   input  logic [31:0] y_in,
   input  logic [31:0] z_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] x_res,
   output logic [31:0] y_res,
   output logic [31:0] z_res,
   output logic [31:0] sa_x,
   output logic [31:0] sa_y,
   output logic [31:0] sa_z,
   output logic [31:0] sa_tan,
   output logic [31:0] sa_i,
   input  logic [31:0] sa_x_out,
   input  logic [31:0] sa_y_out,
   input  logic [31:0] sa_z_out
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_CAPT} state_t;

   localparam logic [4:0] K_LAST = 5'(ITERATIONS - 1);

   state_t      r_state;
   logic [4:0]  r_k;
   logic [31:0] r_x, r_y, r_z;
   logic [31:0] r_x_res, r_y_res, r_z_res;
   logic        r_busy, r_done;
   logic [31:0] w_lx, w_ly, w_lz;

   // atan(2^-i) in binary-angle units, 2^32 = one full turn
   function automatic logic [31:0] atan_rom(input logic [4:0] i);
      case (i)
         5'd0:  atan_rom = 32'h20000000;
         5'd1:  atan_rom = 32'h12E4051E;
         5'd2:  atan_rom = 32'h09FB385B;
         5'd3:  atan_rom = 32'h051111D4;
         5'd4:  atan_rom = 32'h028B0D43;
         5'd5:  atan_rom = 32'h0145D7E1;
         5'd6:  atan_rom = 32'h00A2F61E;
         5'd7:  atan_rom = 32'h00517C55;
         5'd8:  atan_rom = 32'h0028BE53;
         5'd9:  atan_rom = 32'h00145F2F;
         5'd10: atan_rom = 32'h000A2F98;
         5'd11: atan_rom = 32'h000517CC;
         5'd12: atan_rom = 32'h00028BE6;
         5'd13: atan_rom = 32'h000145F3;
         5'd14: atan_rom = 32'h0000A2FA;
         5'd15: atan_rom = 32'h0000517D;
         5'd16: atan_rom = 32'h000028BE;
         5'd17: atan_rom = 32'h0000145F;
         5'd18: atan_rom = 32'h00000A30;
         5'd19: atan_rom = 32'h00000518;
         5'd20: atan_rom = 32'h0000028C;
         5'd21: atan_rom = 32'h00000146;
         5'd22: atan_rom = 32'h000000A3;
         5'd23: atan_rom = 32'h00000051;
         5'd24: atan_rom = 32'h00000029;
         5'd25: atan_rom = 32'h00000014;
         5'd26: atan_rom = 32'h0000000A;
         5'd27: atan_rom = 32'h00000005;
         5'd28: atan_rom = 32'h00000003;
         5'd29: atan_rom = 32'h00000001;
         5'd30: atan_rom = 32'h00000001;
         default: atan_rom = 32'h00000000;
      endcase
   endfunction

   always_comb begin
      w_lx = x_in;
      w_ly = y_in;
      w_lz = z_in;
`ifdef CORDIC_QUADRANT_CORRECTION_EN
      // Rotate by +/-90 degrees up front so the residual angle stays within CORDIC convergence
      if ($signed(z_in) > 32'sh40000000) begin
         w_lx = -y_in;
         w_ly = x_in;
         w_lz = z_in - 32'h40000000;
      end else if ($signed(z_in) < -32'sh40000000) begin
         w_lx = y_in;
         w_ly = -x_in;
         w_lz = z_in + 32'h40000000;
      end
`endif
   end

   always_comb begin
      sa_x   = r_x;
      sa_y   = r_y;
      sa_z   = r_z;
      sa_i   = 32'd0;
      sa_tan = atan_rom(5'd0);
      if (r_state == S_ITER) begin
         sa_i   = {27'd0, r_k};
         sa_tan = atan_rom(r_k);
         if (r_k != 5'd0) begin
            sa_x = sa_x_out;
            sa_y = sa_y_out;
            sa_z = sa_z_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_k     <= 5'd0;
         r_x     <= 32'd0;
         r_y     <= 32'd0;
         r_z     <= 32'd0;
         r_x_res <= 32'd0;
         r_y_res <= 32'd0;
         r_z_res <= 32'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x     <= w_lx;
                  r_y     <= w_ly;
                  r_z     <= w_lz;
                  r_k     <= 5'd0;
                  r_busy  <= 1'b1;
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               r_k <= r_k + 5'd1;
               if (r_k == K_LAST) r_state <= S_CAPT;
            end
            S_CAPT: begin
               // Stage output now holds the last micro-rotation
               r_x_res <= sa_x_out;
               r_y_res <= sa_y_out;
               r_z_res <= sa_z_out;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign x_res = r_x_res;
   assign y_res = r_y_res;
   assign z_res = r_z_res;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: models the external shift-accumulate stage and checks results
// against an iterative CORDIC reference whose angle table is computed from $atan.
module tb_cordic_iter_ctrl;

   localparam int  ITERATIONS = 16;
   localparam int  MAX_WAIT   = 60;
   localparam real PI         = 3.14159265358979323846;

   logic               clk = 1'b0;
   logic               rst, start;
   logic signed [31:0] x_in, y_in, z_in;
   logic               busy, done;
   logic signed [31:0] x_res, y_res, z_res;
   logic signed [31:0] sa_x, sa_y, sa_z;
   logic        [31:0] sa_tan, sa_i;
   logic signed [31:0] sa_x_out, sa_y_out, sa_z_out;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] rom[32];
   logic [95:0] exp_q[$];

   cordic_iter_ctrl #(.ITERATIONS(ITERATIONS)) dut (
      .clk(clk), .rst(rst), .start(start),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .busy(busy), .done(done),
      .x_res(x_res), .y_res(y_res), .z_res(z_res),
      .sa_x(sa_x), .sa_y(sa_y), .sa_z(sa_z),
      .sa_tan(sa_tan), .sa_i(sa_i),
      .sa_x_out(sa_x_out), .sa_y_out(sa_y_out), .sa_z_out(sa_z_out)
   );

   always #5 clk = ~clk;

   // External shift-accumulate stage: one registered micro-rotation, no reset, no enable
   always @(posedge clk) begin
      if (sa_z >= 0) begin
         sa_x_out <= sa_x - (sa_y >>> sa_i);
         sa_y_out <= sa_y + (sa_x >>> sa_i);
         sa_z_out <= sa_z - sa_tan;
      end else begin
         sa_x_out <= sa_x + (sa_y >>> sa_i);
         sa_y_out <= sa_y - (sa_x >>> sa_i);
         sa_z_out <= sa_z + sa_tan;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_tol(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] target);
      logic signed [32:0] d;
      logic               in_tol;
      d      = {obs[31], obs} - {target[31], target};
      in_tol = (d <= 33'sh10000) && (d >= -33'sh10000);
      total++;
      assert (in_tol === 1'b1) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h+/-10000", tag, obs, target);
      end
   endtask

   function automatic logic [95:0] pre_rot(input logic signed [31:0] xi, yi, zi);
      logic [95:0] r;
      r = {xi, yi, zi};
`ifdef CORDIC_QUADRANT_CORRECTION_EN
      if (zi > 32'sh40000000)       r = {-yi, xi, zi - 32'sh40000000};
      else if (zi < -32'sh40000000) r = {yi, -xi, zi + 32'sh40000000};
`endif
      return r;
   endfunction

   function automatic logic [95:0] ref_op(input logic signed [31:0] xi, yi, zi);
      logic [95:0]        p;
      logic signed [31:0] x, y, z, xn;
      p = pre_rot(xi, yi, zi);
      x = p[95:64];
      y = p[63:32];
      z = p[31:0];
      for (int i = 0; i < ITERATIONS; i++) begin
         if (z >= 0) begin
            xn = x - (y >>> i);
            y  = y + (x >>> i);
            z  = z - rom[i];
         end else begin
            xn = x + (y >>> i);
            y  = y - (x >>> i);
            z  = z + rom[i];
         end
         x = xn;
      end
      return {x, y, z};
   endfunction

   task automatic launch(input logic [31:0] x, y, z);
      logic [95:0] p;
      x_in  = x;
      y_in  = y;
      z_in  = z;
      start = 1'b1;
      exp_q.push_back(ref_op(x, y, z));
      p = pre_rot(x, y, z);
      tick();
      start = 1'b0;
      check("busy_k0", busy, 1);
      check("sa_x_k0", sa_x, p[95:64]);
      check("sa_y_k0", sa_y, p[63:32]);
      check("sa_z_k0", sa_z, p[31:0]);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < MAX_WAIT) begin
         if (lat < ITERATIONS) begin
            check("sa_i", sa_i, lat);
            check("sa_tan", sa_tan, rom[lat]);
         end
         tick();
         lat++;
      end
      if (done !== 1'b1) check("done_timeout", done, 1);
   endtask

   task automatic check_result();
      logic [95:0] e;
      if (exp_q.size() == 0) begin
         check("sb_empty", exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
         check("x_res", x_res, e[95:64]);
         check("y_res", y_res, e[63:32]);
         check("z_res", z_res, e[31:0]);
      end
   endtask

   task automatic run_op(input logic [31:0] x, y, z);
      int lat;
      launch(x, y, z);
      wait_done(lat);
      check("latency", lat, ITERATIONS + 1);
      check("busy_at_done", busy, 0);
      check_result();
      tick();
      check("done_one_cycle", done, 0);
   endtask

   function automatic logic [31:0] rand_z();
      return $urandom_range(0, 32'h80000000) - 32'h40000000;
   endfunction

   function automatic logic [31:0] rand_xy();
      return $urandom_range(0, 32'h40000000) - 32'h20000000;
   endfunction

   initial begin
      int lat;
      int seen;
      logic [31:0] cx, cy, cz;

      for (int i = 0; i < 32; i++)
         rom[i] = 32'($rtoi($atan(1.0 / (2.0 ** i)) * 2147483648.0 / PI + 0.5));

      // reset with start held high: start must be ignored
      rst   = 1'b1;
      start = 1'b1;
      x_in  = 32'h12345678;
      y_in  = 32'h0BADF00D;
      z_in  = 32'h01000000;
      repeat (3) tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_x_res", x_res, 0);
      check("rst_y_res", y_res, 0);
      check("rst_z_res", z_res, 0);
      check("idle_sa_x", sa_x, 0);
      check("idle_sa_i", sa_i, 0);
      check("idle_sa_tan", sa_tan, rom[0]);
      repeat (3) tick();
      check("idle_no_start", busy, 0);

      // unit vector pre-scaled by 1/K at angle 0 and 45 degrees
      run_op(32'h26DD3B6A, 32'h0, 32'h0);
      check_tol("v0_x", x_res, 32'sh40000000);
      check_tol("v0_y", y_res, 32'sh0);
      run_op(32'h26DD3B6A, 32'h0, 32'h20000000);
      check_tol("v45_x", x_res, 32'sh2D413CCD);
      check_tol("v45_y", y_res, 32'sh2D413CCD);
      check_tol("v45_z", z_res, 32'sh0);
      run_op(32'h26DD3B6A, 32'h0, 32'h40000000);
      run_op(32'h26DD3B6A, 32'h0, 32'hC0000000);

      for (int n = 0; n < 6; n++) run_op(rand_xy(), rand_xy(), rand_z());

      // start pulse while busy is ignored; start held through done is taken back-to-back
      launch(32'h26DD3B6A, 32'h0, 32'h10000000);
      cx  = rand_xy();
      cy  = rand_xy();
      cz  = rand_z();
      lat = 0;
      while (done !== 1'b1 && lat < MAX_WAIT) begin
         if (lat == 4) begin
            x_in  = rand_xy();
            y_in  = rand_xy();
            z_in  = rand_z();
            start = 1'b1;
         end else if (lat == 5) begin
            start = 1'b0;
         end
         if (lat == 10) begin
            x_in  = cx;
            y_in  = cy;
            z_in  = cz;
            start = 1'b1;
         end
         tick();
         lat++;
      end
      check("b2b_first_latency", lat, ITERATIONS + 1);
      check_result();
      exp_q.push_back(ref_op(cx, cy, cz));
      tick();
      start = 1'b0;
      check("b2b_accept_busy", busy, 1);
      check("b2b_accept_done", done, 0);
      wait_done(lat);
      check("b2b_second_latency", lat, ITERATIONS + 1);
      check_result();
      tick();

      // reset in the middle of an operation
      launch(rand_xy(), rand_xy(), rand_z());
      repeat (7) tick();
      check("mid_sa_i", sa_i, 7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_x_res", x_res, 0);
      check("mid_rst_y_res", y_res, 0);
      check("mid_rst_z_res", z_res, 0);
      check("mid_rst_sa_x", sa_x, 0);
      seen = 0;
      for (int n = 0; n < 25; n++) begin
         if (done === 1'b1 || busy === 1'b1) seen++;
         tick();
      end
      check("no_stale_activity", seen, 0);
      check("no_stale_x_res", x_res, 0);
      run_op(32'h26DD3B6A, 32'h0, 32'h0);
      check_tol("post_rst_x", x_res, 32'sh40000000);
      run_op(rand_xy(), rand_xy(), rand_z());

`ifdef CORDIC_QUADRANT_CORRECTION_EN
      run_op(32'h26DD3B6A, 32'h0, 32'h60000000);
      check_tol("q_x", x_res, -32'sh2D413CCD);
      check_tol("q_y", y_res, 32'sh2D413CCD);
      run_op(32'h26DD3B6A, 32'h0, 32'hA0000000);
      for (int n = 0; n < 3; n++) run_op(rand_xy(), rand_xy(), $urandom);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
